// File: rtl/matrix_mac_engine_if.sv
// Bus bundle for matrix_mac_engine: control handshake, operand matrices and
// result/status outputs. The engine connects through the slave modport and
// the requester connects through the master modport.
interface matrix_mac_engine_if #(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32
);
    logic                        ena;
    logic                        start;
    logic                        sat_mode;
    logic signed [WIDTH_BIT-1:0] MatrixA [AROWS][ACOLUMNS];
    logic signed [WIDTH_BIT-1:0] MatrixB [ACOLUMNS][BCOLUMNS];
    logic signed [WIDTH_BIT-1:0] MatrixO [AROWS][BCOLUMNS];
    logic                        busy;
    logic                        done;
    logic                        overflow;

    modport master (
        output ena, start, sat_mode, MatrixA, MatrixB,
        input  MatrixO, busy, done, overflow
    );

    modport slave (
        input  ena, start, sat_mode, MatrixA, MatrixB,
        output MatrixO, busy, done, overflow
    );
endinterface

// File: rtl/matrix_mac_engine.sv
// Signed matrix multiply-accumulate engine: O = A x B.
// The result is produced tile by tile: one row of A against a group of LANES
// columns of B, one inner-dimension step per enabled cycle, followed by a
// single write cycle that converts (saturate or wrap) and stores each lane.
module matrix_mac_engine #(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32,
    parameter int LANES     = 1,
    parameter int ACC_WIDTH = 2 * WIDTH_BIT + $clog2(ACOLUMNS) + 1
) (
    input logic                clock,
    input logic                nreset,
    matrix_mac_engine_if.slave bus
);
    localparam int ACC_MIN = 2 * WIDTH_BIT + $clog2(ACOLUMNS) + 1;
    localparam int IW      = (AROWS > 1) ? $clog2(AROWS) : 1;
    localparam int KW      = (ACOLUMNS > 1) ? $clog2(ACOLUMNS) : 1;
    localparam int CW      = (BCOLUMNS > 1) ? $clog2(BCOLUMNS) : 1;
    localparam int JW      = $clog2(BCOLUMNS + LANES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // A narrower accumulator could silently lose the sum of K full products.
    generate
        if (ACC_WIDTH < ACC_MIN) begin : g_acc_width_check
            $error("matrix_mac_engine: ACC_WIDTH below minimum");
        end
        if ((LANES < 1) || (LANES > BCOLUMNS)) begin : g_lanes_check
            $error("matrix_mac_engine: LANES must be in 1..BCOLUMNS");
        end
    endgenerate

    // Convert an accumulator to the element width. Returns {overflow, value}.
    // Overflow means the bits above the element sign bit are not a pure sign
    // extension; in saturate mode the value clips toward the sign of acc.
    function automatic logic [WIDTH_BIT:0] convert_f(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic                        sat
    );
        logic [ACC_WIDTH-WIDTH_BIT:0] hi;
        logic                         ovf;
        logic [WIDTH_BIT-1:0]         val;
        hi  = acc[ACC_WIDTH-1:WIDTH_BIT-1];
        ovf = !((&hi) || !(|hi));
        if (ovf && sat) begin
            if (acc[ACC_WIDTH-1]) begin
                val = {1'b1, {(WIDTH_BIT-1){1'b0}}};
            end else begin
                val = {1'b0, {(WIDTH_BIT-1){1'b1}}};
            end
        end else begin
            val = acc[WIDTH_BIT-1:0];
        end
        return {ovf, val};
    endfunction

    logic [2:0]                  state_r;
    logic [IW-1:0]               row_r;
    logic [KW-1:0]               k_r;
    logic [JW-1:0]               col_r;
    logic                        sat_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        ovf_r;
    logic signed [WIDTH_BIT-1:0] a_r   [AROWS][ACOLUMNS];
    logic signed [WIDTH_BIT-1:0] b_r   [ACOLUMNS][BCOLUMNS];
    logic signed [WIDTH_BIT-1:0] out_r [AROWS][BCOLUMNS];
    logic signed [ACC_WIDTH-1:0] acc_r [LANES];

    logic signed [WIDTH_BIT-1:0]   a_elem_s;
    logic signed [WIDTH_BIT-1:0]   b_elem_s   [LANES];
    logic signed [2*WIDTH_BIT-1:0] prod_s     [LANES];
    logic [WIDTH_BIT-1:0]          conv_s     [LANES];
    logic [LANES-1:0]              lane_act_s;
    logic [LANES-1:0]              lane_ovf_s;
    logic                          k_last_s;
    logic                          row_end_s;
    logic                          last_tile_s;

    // Per-lane operand fetch, product, conversion and tile-walk decisions.
    always_comb begin
        logic [CW-1:0]      col_idx_v;
        logic [WIDTH_BIT:0] conv_v;
        col_idx_v   = '0;
        conv_v      = '0;
        a_elem_s    = a_r[row_r][k_r];
        k_last_s    = (k_r == KW'(ACOLUMNS - 1));
        row_end_s   = ((col_r + JW'(LANES)) >= JW'(BCOLUMNS));
        last_tile_s = row_end_s && (row_r == IW'(AROWS - 1));
        for (int l = 0; l < LANES; l++) begin
            lane_act_s[l] = ((col_r + JW'(l)) < JW'(BCOLUMNS));
            col_idx_v     = lane_act_s[l] ? CW'(col_r + JW'(l)) : '0;
            b_elem_s[l]   = lane_act_s[l] ? b_r[k_r][col_idx_v] : '0;
            prod_s[l]     = (2*WIDTH_BIT)'(a_elem_s) * (2*WIDTH_BIT)'(b_elem_s[l]);
            conv_v        = convert_f(acc_r[l], sat_r);
            lane_ovf_s[l] = conv_v[WIDTH_BIT];
            conv_s[l]     = conv_v[WIDTH_BIT-1:0];
        end
    end

    // Job FSM with operand capture, accumulation and result write-back.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r <= S_IDLE;
            row_r   <= '0;
            k_r     <= '0;
            col_r   <= '0;
            sat_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            for (int r = 0; r < AROWS; r++) begin
                for (int c = 0; c < ACOLUMNS; c++) a_r[r][c] <= '0;
                for (int c = 0; c < BCOLUMNS; c++) out_r[r][c] <= '0;
            end
            for (int r = 0; r < ACOLUMNS; r++) begin
                for (int c = 0; c < BCOLUMNS; c++) b_r[r][c] <= '0;
            end
            for (int l = 0; l < LANES; l++) acc_r[l] <= '0;
        end else if (bus.ena) begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    // A start coinciding with the done pulse is not a new request.
                    if (bus.start && !done_r) begin
                        state_r <= S_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    a_r     <= bus.MatrixA;
                    b_r     <= bus.MatrixB;
                    sat_r   <= bus.sat_mode;
                    ovf_r   <= 1'b0;
                    row_r   <= '0;
                    col_r   <= '0;
                    k_r     <= '0;
                    for (int l = 0; l < LANES; l++) acc_r[l] <= '0;
                    state_r <= S_MAC;
                end
                S_MAC: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_r[l] <= acc_r[l] + ACC_WIDTH'(prod_s[l]);
                    end
                    if (k_last_s) begin
                        k_r     <= '0;
                        state_r <= S_WRITE;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                S_WRITE: begin
                    for (int r = 0; r < AROWS; r++) begin
                        for (int c = 0; c < BCOLUMNS; c++) begin
                            for (int l = 0; l < LANES; l++) begin
                                if (lane_act_s[l] && (row_r == IW'(r)) &&
                                    ((col_r + JW'(l)) == JW'(c))) begin
                                    out_r[r][c] <= conv_s[l];
                                end
                            end
                        end
                    end
                    ovf_r <= ovf_r | (|(lane_ovf_s & lane_act_s));
                    for (int l = 0; l < LANES; l++) acc_r[l] <= '0;
                    if (last_tile_s) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_MAC;
                        if (row_end_s) begin
                            col_r <= '0;
                            row_r <= row_r + IW'(1);
                        end else begin
                            col_r <= col_r + JW'(LANES);
                        end
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.MatrixO  = out_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
endmodule
